// File: rtl/ex_alu_unit_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encodings, mul/div FSM
// states and datapath sizing constants.
package ex_alu_unit_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_SLL   = 5'd10,
    OP_SRL   = 5'd11,
    OP_SRA   = 5'd12,
    OP_LUI   = 5'd13,
    OP_MFHI  = 5'd14,
    OP_MFLO  = 5'd15,
    OP_MULT  = 5'd16,
    OP_MULTU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_alu_unit_if.sv
// Operation/result bus between the ALU-source mux stage and the execute ALU.
interface ex_alu_unit_if;
  import ex_alu_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       ALUOp;
  logic [4:0]       shamt;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, A, B, ALUOp, shamt,
    input  in_ready, out_valid, result, zero, overflow, hi, lo
  );

  modport slave (
    input  in_valid, A, B, ALUOp, shamt,
    output in_ready, out_valid, result, zero, overflow, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative 32-cycle multiplier (shift-add) and restoring divider operating on
// magnitudes, with a final cycle that applies sign correction.
module ex_muldiv_iter
  import ex_alu_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [WIDTH-1:0]  bmag_q, bmag_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dbz_q, dbz_d;
  logic              div_q, div_d;

  logic [32:0]       mul_sum;
  logic [32:0]       div_r;
  logic [32:0]       div_diff;
  logic [63:0]       prod_fix;
  logic [WIDTH-1:0]  quot, rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      div_q   <= div_d;
    end
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, bmag_q};
  assign div_r    = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_r - {1'b0, bmag_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    div_d   = div_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          acc_d   = {32'd0, (signed_op_i && a_i[31]) ? -a_i : a_i};
          bmag_d  = (signed_op_i && b_i[31]) ? -b_i : b_i;
          qneg_d  = signed_op_i && (a_i[31] ^ b_i[31]);
          rneg_d  = signed_op_i && a_i[31];
          dbz_d   = (b_i == '0);
          div_d   = is_div_i;
          cnt_d   = '0;
          state_d = is_div_i ? MD_DIV : MD_MUL;
        end
      end
      MD_MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = MD_FIX;
      end
      MD_DIV: begin
        acc_d = div_diff[32] ? {div_r[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = MD_FIX;
      end
      default: begin
        cnt_d   = '0;
        state_d = MD_IDLE;
      end
    endcase
  end

  assign prod_fix = qneg_q ? -acc_q : acc_q;
  assign quot     = acc_q[31:0];
  assign rem      = acc_q[63:32];

  // A zero divisor yields all-ones quotient magnitude; force it past the sign fix
  always_comb begin
    if (div_q) begin
      hi_o = rneg_q ? -rem : rem;
      lo_o = dbz_q ? '1 : (qneg_q ? -quot : quot);
    end else begin
      hi_o = prod_fix[63:32];
      lo_o = prod_fix[31:0];
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = (state_q == MD_FIX);

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle integer ops with registered outputs, plus
// HI/LO registers fed by the iterative mul/div unit.
module ex_alu_unit
  import ex_alu_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ex_alu_unit_if.slave bus
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             in_ready, accept, md_op, md_start;
  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic             alu_ovf;
  alu_op_e          op;

  assign op       = alu_op_e'(bus.ALUOp);
  assign in_ready = ~md_busy;
  assign accept   = bus.in_valid && in_ready;
  assign md_op    = is_muldiv(bus.ALUOp);
  assign md_start = accept && md_op;

  ex_muldiv_iter u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (md_start),
    .signed_op_i ((op == OP_MULT) || (op == OP_DIV)),
    .is_div_i    ((op == OP_DIV) || (op == OP_DIVU)),
    .a_i         (bus.A),
    .b_i         (bus.B),
    .busy_o      (md_busy),
    .done_o      (md_done),
    .hi_o        (md_hi),
    .lo_o        (md_lo)
  );

  assign add_res = bus.A + bus.B;
  assign sub_res = bus.A - bus.B;

  always_comb begin
    alu_res = add_res;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (bus.A[31] == bus.B[31]) && (add_res[31] != bus.A[31]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (bus.A[31] != bus.B[31]) && (sub_res[31] != bus.A[31]);
      end
      OP_SUBU: alu_res = sub_res;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_NOR:  alu_res = ~(bus.A | bus.B);
      OP_SLT:  alu_res = {31'd0, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: alu_res = {31'd0, bus.A < bus.B};
      OP_SLL:  alu_res = bus.B << bus.shamt;
      OP_SRL:  alu_res = bus.B >> bus.shamt;
      OP_SRA:  alu_res = 32'($signed(bus.B) >>> bus.shamt);
      OP_LUI:  alu_res = {bus.B[15:0], 16'h0000};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = add_res;
    endcase
  end

  // A mul/div completion and a new accept cannot coincide: in_ready is low in FIX
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    if (md_done) begin
      hi_d        = md_hi;
      lo_d        = md_lo;
      result_d    = md_lo;
      zero_d      = (md_lo == '0);
      ovf_d       = 1'b0;
      out_valid_d = 1'b1;
    end else if (accept && !md_op) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed corner cases then random ops,
// checked against an arithmetic reference model.
module tb_ex_alu_unit;
  import ex_alu_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_alu_unit_if bus();

  ex_alu_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: plain arithmetic on the architectural HI/LO state
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output exp_t e);
    longint      s;
    longint      sp;
    logic [63:0] p;
    int          sa, sb;
    logic [31:0] r;
    logic        ov;
    logic        md;
    r  = a + b;
    ov = 1'b0;
    md = 1'b0;
    sa = a;
    sb = b;
    case (op)
      OP_ADD: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        r  = a + b;
        ov = (s != longint'($signed(r)));
      end
      OP_SUB: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        r  = a - b;
        ov = (s != longint'($signed(r)));
      end
      OP_SUBU: r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = 32'(sb >>> sh);
      OP_LUI:  r = {b[15:0], 16'h0000};
      OP_MFHI: r = m_hi;
      OP_MFLO: r = m_lo;
      OP_MULT: begin
        sp = longint'(sa) * longint'(sb);
        p  = sp;
        m_hi = p[63:32]; m_lo = p[31:0]; md = 1'b1;
      end
      OP_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; md = 1'b1;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFFFFFF;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_hi = 32'd0; m_lo = 32'h80000000;
        end else begin
          m_lo = sa / sb; m_hi = sa % sb;
        end
        md = 1'b1;
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFFFFFF;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        md = 1'b1;
      end
      default: r = a + b;
    endcase
    if (md) begin
      r  = m_lo;
      ov = 1'b0;
    end
    e.result = r;
    e.zero   = (r == 32'd0);
    e.ovf    = ov;
    e.hi     = m_hi;
    e.lo     = m_lo;
  endtask

  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    int   w;
    model(op, a, b, sh, e);
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUOp    = op;
    bus.A        = a;
    bus.B        = b;
    bus.shamt    = sh;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout_%s: in_ready stayed 0 for %0d cycles, required 1", name, w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  // Monitor: one scoreboard pop per out_valid cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out_valid: result=%h, required no pulse", bus.result);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] %s result=%h zero=%0b ovf=%0b hi=%h lo=%h", e.name, bus.result,
                   bus.zero, bus.overflow, bus.hi, bus.lo);
          check({e.name, "_result"}, bus.result, e.result);
          check({e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, e.zero});
          check({e.name, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e.ovf});
          check({e.name, "_hi"}, bus.hi, e.hi);
          check({e.name, "_lo"}, bus.lo, e.lo);
        end
      end
    end
  end

  initial begin
    int          c;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.ALUOp    = '0;
    bus.shamt    = '0;

    #2;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0);
    issue("addu_wrap", OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0);
    issue("lui", OP_LUI, 32'h0, 32'hFFFFDEAD, 5'd0);
    issue("slt", OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0);
    issue("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0);
    issue("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd0);
    issue("sra", OP_SRA, 32'd0, 32'h80000F00, 5'd4);
    drain();

    issue("mult", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 5'd0);
    c = 0;
    @(negedge clk);
    while (!bus.in_ready && c < 100) begin
      c++;
      @(negedge clk);
    end
    check("mult_busy_cycles", c, 32'd33);
    issue("mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0);
    issue("mflo", OP_MFLO, 32'd0, 32'd0, 5'd0);

    issue("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 5'd0);
    issue("divu_by0", OP_DIVU, 32'h00001234, 32'h0, 5'd0);
    issue("div_by0_neg", OP_DIV, 32'hFFFFFF00, 32'h0, 5'd0);
    issue("div_minint", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    issue("divu", OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 5'd0);
    issue("add_held", OP_ADD, 32'd10, 32'd20, 5'd0);
    drain();

    issue("mult_rst", OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 5'd0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    check("mrst_hi", bus.hi, 32'd0);
    check("mrst_lo", bus.lo, 32'd0);
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue("add_after_rst", OP_ADD, 32'd2, 32'd3, 5'd0);
    drain();

    for (int i = 0; i < 250; i++) begin
      rop = 5'($urandom_range(0, 21));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: ra = rb;
        default: ;
      endcase
      issue($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
